// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake constant/sequence source.
// Generator modes, the stats counter width and a constant-foldable ceil-log2.
package handshake_pkg;

    localparam int MODE_CONST  = 0;
    localparam int MODE_STEP   = 1;
    localparam int STATS_WIDTH = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/handshake_slot_fifo.sv
// DEPTH-slot elastic buffer with wrap-at-DEPTH pointers (DEPTH need not be a power of two).
// Latency: 1 cycle push to head visible; no bypass path.
// Backpressure: push ignored while full; a pop frees a slot for the next cycle only.
module handshake_slot_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_vld_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_rdy_i,
    output logic [DATA_WIDTH-1:0] head_dat_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign full_o     = (cnt_q == CNT_FULL);
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_vld_i && !full_o;
    assign do_pop     = pop_rdy_i && !empty_o;
    assign head_dat_o = empty_o ? '0 : mem_q[head_q];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Slot contents need no reset: an empty count masks stale data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// Constant / arithmetic-step word source: one outs word per accepted ctrl token.
// Latency: 1 cycle accept to outs_valid; ctrl_ready = !full, independent of outs_ready.
// Backpressure: buffers DEPTH words, then stalls ctrl. HANDSHAKE_CONST_STATS_EN adds tok_count.
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VALUE      = 9,
    parameter int MODE       = MODE_CONST,
    parameter int STEP       = 1,
    parameter int DEPTH      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_valid,
    output logic                   ctrl_ready,
    output logic [DATA_WIDTH-1:0]  outs,
    output logic                   outs_valid,
    input  logic                   outs_ready
`ifdef HANDSHAKE_CONST_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] tok_count
`endif
);

    localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP_VAL = DATA_WIDTH'(STEP);

    logic [DATA_WIDTH-1:0] gen_q, gen_d;
    logic                  full, empty;
    logic                  accept;

    assign ctrl_ready = !full;
    assign outs_valid = !empty;
    assign accept     = ctrl_valid && !full;

    always_comb begin
        gen_d = gen_q;
        if (MODE == MODE_STEP) begin
            if (accept) begin
                gen_d = gen_q + STEP_VAL;
            end
        end else begin
            gen_d = INIT_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gen_q <= INIT_VAL;
        end else begin
            gen_q <= gen_d;
        end
    end

    handshake_slot_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (ctrl_valid),
        .push_dat_i (gen_q),
        .pop_rdy_i  (outs_ready),
        .head_dat_o (outs),
        .full_o     (full),
        .empty_o    (empty)
    );

`ifdef HANDSHAKE_CONST_STATS_EN
    logic [STATS_WIDTH-1:0] tok_q, tok_d;
    logic                   deliver;

    assign deliver   = outs_ready && !empty;
    assign tok_count = tok_q;

    always_comb begin
        tok_d = tok_q;
        if (deliver && (tok_q != '1)) begin
            tok_d = tok_q + STATS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tok_q <= '0;
        end else begin
            tok_q <= tok_d;
        end
    end
`endif

endmodule
